// File: rtl/retire_trace_buffer.sv
// Instruction-retire trace recorder: snoops the datapath retire strobe and captures
// timestamped {stamp, pc, ir, a, f} entries into a ring buffer, drained over valid/ready.
module retire_trace_buffer #(
    parameter int DEPTH   = 64,
    parameter int PC_W    = 16,
    parameter int CYC_W   = 32,
    parameter int ENTRY_W = CYC_W + PC_W + 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       retire,
    input  logic [PC_W-1:0]            pc,
    input  logic [7:0]                 ir,
    input  logic [7:0]                 reg_a,
    input  logic [7:0]                 reg_f,
    input  logic                       arm,
    input  logic                       trig_en,
    input  logic [PC_W-1:0]            trig_pc,
    input  logic                       wrap_mode,
    input  logic                       stop,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [ENTRY_W-1:0]         rd_data,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [CYC_W-1:0]           cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic [PC_W-1:0]    trig_pc_q, trig_pc_d;
    logic               wrap_q, wrap_d;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               wr_en;
    logic [ENTRY_W-1:0] wr_entry;
    logic               rd_valid_c;
    logic               pop;
    logic               hit;

    assign wr_entry   = {cycles_q, pc, ir, reg_a, reg_f};
    assign rd_valid_c = (state_q == DONE) && (count_q != '0);
    assign pop        = rd_valid_c && rd_ready;
    assign hit        = retire && (pc == trig_pc_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        trig_pc_d  = trig_pc_q;
        wrap_d     = wrap_q;
        wr_en      = 1'b0;
        cycles_d   = cycles_q + CYC_W'(1);

        if (arm) begin
            state_d    = trig_en ? ARMED : CAPTURE;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            trig_pc_d  = trig_pc;
            wrap_d     = wrap_mode;
        end else begin
            case (state_q)
                ARMED: begin
                    if (stop) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else if (hit) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        count_d  = count_q + CNT_W'(1);
                        state_d  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (retire) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        // Full only happens in wrap mode: the write lands on the oldest slot.
                        if (count_q == FULL) begin
                            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                            if (!wrap_q && (count_q == FULL - CNT_W'(1)))
                                state_d = DONE;
                        end
                    end
                    if (stop)
                        state_d = DONE;
                end
                DONE: begin
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        count_d  = count_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            cycles_q   <= '0;
            trig_pc_q  <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            cycles_q   <= cycles_d;
            trig_pc_q  <= trig_pc_d;
            wrap_q     <= wrap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= wr_entry;
    end

    assign state    = state_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign cycles   = cycles_q;
    assign rd_valid = rd_valid_c;
    assign rd_data  = rd_valid_c ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer (DEPTH=4): table rows per cycle plus a
// scoreboard of expected entries for drains, reset and handshake corner cases.
module tb_retire_trace_buffer;

    localparam int DEPTH = 4;
    localparam int PC_W  = 16;
    localparam int CYC_W = 32;
    localparam int EW    = CYC_W + PC_W + 24;

    logic            clk, rst;
    logic            retire, arm, trig_en, wrap_mode, stop, rd_ready;
    logic [PC_W-1:0] pc, trig_pc;
    logic [7:0]      ir, reg_a, reg_f;
    logic            rd_valid, overflow;
    logic [EW-1:0]   rd_data;
    logic [1:0]      state;
    logic [2:0]      count;
    logic [CYC_W-1:0] cycles;

    retire_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .ir(ir), .reg_a(reg_a),
        .reg_f(reg_f), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .wrap_mode(wrap_mode), .stop(stop), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .state(state), .count(count), .overflow(overflow),
        .cycles(cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [CYC_W-1:0] tb_cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 1;
    end

    typedef struct {
        int              seg;
        logic            arm, ten, wrap, stop, retire;
        logic [PC_W-1:0] tpc, pc;
        logic            cap, ovr;
        logic [1:0]      e_state;
        logic [2:0]      e_count;
        logic            e_ovf;
    } vec_t;

    vec_t          tbl[$];
    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] entry(input logic [PC_W-1:0] p, input logic [CYC_W-1:0] s);
        return {s, p, p[7:0], ~p[7:0], {p[3:0], 4'h0}};
    endfunction

    task automatic row(input int seg, input logic a, input logic ten, input logic [PC_W-1:0] tpc,
                       input logic wr, input logic st, input logic re, input logic [PC_W-1:0] p,
                       input logic cap, input logic ovr, input logic [1:0] es,
                       input logic [2:0] ec, input logic eo);
        vec_t v;
        v.seg = seg; v.arm = a; v.ten = ten; v.tpc = tpc; v.wrap = wr; v.stop = st;
        v.retire = re; v.pc = p; v.cap = cap; v.ovr = ovr;
        v.e_state = es; v.e_count = ec; v.e_ovf = eo;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seg(input int k);
        vec_t v;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].seg == k) begin
                v = tbl[i];
                arm = v.arm; trig_en = v.ten; trig_pc = v.tpc; wrap_mode = v.wrap;
                stop = v.stop; retire = v.retire; pc = v.pc;
                ir = v.pc[7:0]; reg_a = ~v.pc[7:0]; reg_f = {v.pc[3:0], 4'h0};
                rd_ready = 1'b0;
                if (v.arm) exp_q.delete();
                if (v.cap) begin
                    if (v.ovr) void'(exp_q.pop_front());
                    exp_q.push_back(entry(v.pc, tb_cyc));
                end
                step();
                arm = 1'b0; stop = 1'b0; retire = 1'b0;
                chk($sformatf("seg%0d row%0d state", k, i), 80'(state), 80'(v.e_state));
                chk($sformatf("seg%0d row%0d count", k, i), 80'(count), 80'(v.e_count));
                chk($sformatf("seg%0d row%0d overflow", k, i), 80'(overflow), 80'(v.e_ovf));
                chk($sformatf("seg%0d row%0d cycles", k, i), 80'(cycles), 80'(tb_cyc));
                chk($sformatf("seg%0d row%0d rd_valid", k, i), 80'(rd_valid),
                    80'((v.e_state == 2'd3) && (v.e_count != 0)));
            end
        end
    endtask

    task automatic drain(input int n, input string name);
        chk({name, " count before drain"}, 80'(count), 80'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s pop%0d rd_valid", name, i), 80'(rd_valid), 80'(1));
            chk($sformatf("%s pop%0d rd_data", name, i), 80'(rd_data), 80'(exp_q[0]));
            rd_ready = 1'b1;
            step();
            void'(exp_q.pop_front());
        end
        rd_ready = 1'b0;
        chk({name, " empty rd_valid"}, 80'(rd_valid), 80'(0));
        chk({name, " empty rd_data"}, 80'(rd_data), 80'(0));
        chk({name, " empty count"}, 80'(count), 80'(0));
    endtask

    logic pat [4];

    initial begin
        // seg 0: IDLE ignores retire/stop
        row(0, 0,0,16'h0000,0, 1,1,16'h0100, 0,0, 2'd0,3'd0,0);
        // seg 1: no trigger, stop-when-full
        row(1, 1,0,16'h0000,0, 0,0,16'h0000, 0,0, 2'd2,3'd0,0);
        row(1, 0,0,16'h0000,0, 0,1,16'h0100, 1,0, 2'd2,3'd1,0);
        row(1, 0,0,16'h0000,0, 0,1,16'h0101, 1,0, 2'd2,3'd2,0);
        row(1, 0,0,16'h0000,0, 0,1,16'h0102, 1,0, 2'd2,3'd3,0);
        row(1, 0,0,16'h0000,0, 0,1,16'h0103, 1,0, 2'd3,3'd4,0);
        row(1, 0,0,16'h0000,0, 0,1,16'h0104, 0,0, 2'd3,3'd4,0);
        // seg 2: PC trigger
        row(2, 1,1,16'h0150,0, 0,0,16'h0000, 0,0, 2'd1,3'd0,0);
        row(2, 0,0,16'h0000,0, 0,1,16'h0148, 0,0, 2'd1,3'd0,0);
        row(2, 0,0,16'h0000,0, 0,1,16'h0150, 1,0, 2'd2,3'd1,0);
        row(2, 0,0,16'h0000,0, 0,1,16'h0151, 1,0, 2'd2,3'd2,0);
        row(2, 0,0,16'h0000,0, 1,0,16'h0000, 0,0, 2'd3,3'd2,0);
        // seg 3: wrap mode overwrite
        row(3, 1,0,16'h0000,1, 0,0,16'h0000, 0,0, 2'd2,3'd0,0);
        row(3, 0,0,16'h0000,0, 0,1,16'h0200, 1,0, 2'd2,3'd1,0);
        row(3, 0,0,16'h0000,0, 0,1,16'h0201, 1,0, 2'd2,3'd2,0);
        row(3, 0,0,16'h0000,0, 0,1,16'h0202, 1,0, 2'd2,3'd3,0);
        row(3, 0,0,16'h0000,0, 0,1,16'h0203, 1,0, 2'd2,3'd4,0);
        row(3, 0,0,16'h0000,0, 0,1,16'h0204, 1,1, 2'd2,3'd4,1);
        row(3, 0,0,16'h0000,0, 0,1,16'h0205, 1,1, 2'd2,3'd4,1);
        row(3, 0,0,16'h0000,0, 1,0,16'h0000, 0,0, 2'd3,3'd4,1);
        // seg 4: three entries for the handshake pattern
        row(4, 1,0,16'h0000,0, 0,0,16'h0000, 0,0, 2'd2,3'd0,0);
        row(4, 0,0,16'h0000,0, 0,1,16'h0300, 1,0, 2'd2,3'd1,0);
        row(4, 0,0,16'h0000,0, 0,1,16'h0301, 1,0, 2'd2,3'd2,0);
        row(4, 0,0,16'h0000,0, 0,1,16'h0302, 1,0, 2'd2,3'd3,0);
        row(4, 0,0,16'h0000,0, 1,0,16'h0000, 0,0, 2'd3,3'd3,0);
        // seg 5: two entries, then reset mid-capture
        row(5, 1,0,16'h0000,0, 0,0,16'h0000, 0,0, 2'd2,3'd0,0);
        row(5, 0,0,16'h0000,0, 0,1,16'h0400, 1,0, 2'd2,3'd1,0);
        row(5, 0,0,16'h0000,0, 0,1,16'h0401, 1,0, 2'd2,3'd2,0);
        // seg 6: retire with arm dropped, retire with stop kept
        row(6, 1,0,16'h0000,0, 0,1,16'h0500, 0,0, 2'd2,3'd0,0);
        row(6, 0,0,16'h0000,0, 1,1,16'h0501, 1,0, 2'd3,3'd1,0);
        // seg 7: DONE with entries, then arm discards them; stop in ARMED idles
        row(7, 1,0,16'h0000,0, 0,0,16'h0000, 0,0, 2'd2,3'd0,0);
        row(7, 0,0,16'h0000,0, 0,1,16'h0600, 1,0, 2'd2,3'd1,0);
        row(7, 0,0,16'h0000,0, 1,1,16'h0601, 1,0, 2'd3,3'd2,0);
        row(7, 1,1,16'h0000,0, 0,0,16'h0000, 0,0, 2'd1,3'd0,0);
        row(7, 0,0,16'h0000,0, 1,0,16'h0000, 0,0, 2'd0,3'd0,0);

        rst = 1'b1; retire = 0; arm = 0; trig_en = 0; wrap_mode = 0; stop = 0;
        rd_ready = 0; pc = '0; trig_pc = '0; ir = '0; reg_a = '0; reg_f = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 80'(state), 80'(0));
        chk("reset count", 80'(count), 80'(0));
        chk("reset overflow", 80'(overflow), 80'(0));
        chk("reset rd_valid", 80'(rd_valid), 80'(0));
        chk("reset rd_data", 80'(rd_data), 80'(0));
        chk("reset cycles", 80'(cycles), 80'(0));
        @(negedge clk) rst = 1'b0;
        step();

        run_seg(0);
        run_seg(1);
        drain(4, "nowrap");
        run_seg(2);
        drain(2, "trigger");
        run_seg(3);
        drain(4, "wrap");
        chk("wrap overflow after drain", 80'(overflow), 80'(1));

        run_seg(4);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hs cyc%0d rd_valid", i), 80'(rd_valid), 80'(1));
            chk($sformatf("hs cyc%0d rd_data", i), 80'(rd_data), 80'(exp_q[0]));
            rd_ready = pat[i];
            step();
            if (pat[i]) void'(exp_q.pop_front());
            chk($sformatf("hs cyc%0d count", i), 80'(count), 80'(exp_q.size()));
        end
        rd_ready = 1'b0;
        chk("hs end rd_valid", 80'(rd_valid), 80'(0));
        chk("hs end rd_data", 80'(rd_data), 80'(0));

        run_seg(5);
        #2 rst = 1'b1;
        #1;
        chk("midrun rst state", 80'(state), 80'(0));
        chk("midrun rst count", 80'(count), 80'(0));
        chk("midrun rst cycles", 80'(cycles), 80'(0));
        chk("midrun rst rd_valid", 80'(rd_valid), 80'(0));
        chk("midrun rst overflow", 80'(overflow), 80'(0));
        @(negedge clk) rst = 1'b0;
        exp_q.delete();
        step();

        run_seg(6);
        drain(1, "arm/stop coincide");
        run_seg(7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Synthesizable, parametrised instruction-retire trace recorder for the GameBoy core. It sits beside `datapath` and snoops its retire strobe, PC, IR, A and F. It captures timestamped entries into an on-chip ring buffer after an optional PC-match trigger. Entries are drained afterwards over a valid/ready port, replacing simulation-only `$monitor` tracing with hardware that also works on the FPGA.

## Interface
Parameters:
- DEPTH, 64: entries in buffer; power of two, ≥2
- PC_W, 16: PC / trigger width
- CYC_W, 32: cycle-stamp width
- ENTRY_W, CYC_W+PC_W+24: derived, do not override

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- retire  in  1  one-cycle strobe, instruction retired this cycle
- pc  in  PC_W  PC of retiring instruction
- ir  in  8  opcode of retiring instruction
- reg_a  in  8  A register at retire
- reg_f  in  8  F register (flags) at retire
- arm  in  1  pulse: clear buffer, latch config, start new run
- trig_en  in  1  sampled at arm; 1 = wait for PC match, 0 = capture immediately
- trig_pc  in  PC_W  sampled at arm; trigger address
- wrap_mode  in  1  sampled at arm; 0 = stop when full, 1 = overwrite oldest
- stop  in  1  ends capture (needed in wrap mode)
- rd_valid  out  1  entry available at rd_data
- rd_ready  in  1  consumer accepts entry
- rd_data  out  ENTRY_W  {stamp, pc, ir, reg_a, reg_f}, MSB→LSB
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- count  out  $clog2(DEPTH)+1  valid entries held
- overflow  out  1  wrap mode discarded ≥1 entry this run
- cycles  out  CYC_W  free-running cycle counter

## Operation
- Reset values: state=IDLE, count=0, overflow=0, rd_valid=0, rd_data=0, cycles=0, pointers=0.
- cycles increments every clk and wraps modulo 2^CYC_W. Stamp = cycles value in the retire cycle.
- arm has priority over every other input in every state. It clears count, pointers and overflow, and latches trig_en, trig_pc and wrap_mode.
  - With trig_en=0, next state is CAPTURE; with trig_en=1, next state is ARMED.
  - A retire in the arm cycle is not captured.
- IDLE: retire, stop and rd_ready are ignored.
- ARMED: retire with pc==trig_pc captures that instruction and moves to CAPTURE. Non-matching retires are dropped. stop returns to IDLE with count=0.
- CAPTURE: each retire writes an entry at wr_ptr; wr_ptr advances modulo DEPTH.
  - wrap_mode=0: the write that makes count==DEPTH also moves to DONE.
  - wrap_mode=1, buffer full: the write overwrites the oldest entry, rd_ptr advances, count stays DEPTH, overflow is set to 1.
  - stop moves to DONE. A retire in the same cycle as stop is captured first.
- DONE: rd_valid = (count≠0). rd_data = mem[rd_ptr] (show-ahead, combinational read), forced to 0 when rd_valid=0.
  - Handshake rd_valid&&rd_ready pops: rd_ptr++ mod DEPTH, count--.
  - Retires are ignored. DONE persists until arm or reset.
- rd_valid is 0 in all states other than DONE. No reads occur during capture.

## Timing
- Capture: entry is written at the clk edge ending the retire cycle. count and state update at the same edge.
- First rd_valid appears in the cycle after the edge that enters DONE.
- Pop: one entry per cycle with rd_ready held high. rd_data shows the next entry in the following cycle.
- Zero-latency full: in wrap_mode=0 the DEPTH-th retire edge enters DONE, and a retire in the next cycle is dropped.
- Reset mid-run discards the buffer immediately, asynchronously, and forces every output to its reset value.
- arm mid-drain discards unread entries. rd_valid drops in the next cycle.

## Test plan
- DEPTH=4, arm with trig_en=0, wrap_mode=0, 5 retires at PC 0x0100–0x0104 → DONE after the 4th; drain yields PCs 0x0100..0x0103 with increasing stamps; overflow=0; 5th retire absent.
- arm with trig_en=1, trig_pc=0x0150, retires at 0x0148, 0x0150, 0x0151, then stop → 2 entries (0x0150, 0x0151); 0x0148 dropped.
- wrap_mode=1, 6 retires (0x0200–0x0205), stop → count=4, overflow=1; drain yields 0x0202..0x0205.
- DONE with 3 entries, rd_ready toggled 1,0,1,1 → pops on cycles 1, 3 and 4 only; rd_valid=0 and rd_data=0 afterwards.
- Assert rst during CAPTURE with 2 entries → same cycle: state=0, count=0, cycles=0, rd_valid=0; arm afterward starts a clean run.
- retire coinciding with arm, then retire coinciding with stop → first not captured, second captured; count=1.
